// File: rtl/bf_data_unit.sv
// Data-memory initiator: owns the data pointer and runs cell commands as RAM read/modify/write sequences.
// Optional BF_DP_TRAP_EN: pointer moves off either end are blocked and raise a sticky ERR output.
module bf_data_unit #(
    parameter int DA_WIDTH = 11,
    parameter int DD_WIDTH = 8
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                CMD_VALID,
    output logic                CMD_READY,
    input  logic [2:0]          CMD,
    input  logic [DD_WIDTH-1:0] WDATA,
    output logic                RSP_VALID,
    output logic [DD_WIDTH-1:0] RSP_DATA,
    output logic                RSP_ZERO,
    output logic [DA_WIDTH-1:0] DP,
    output logic [DA_WIDTH-1:0] MEM_A,
    output logic [DD_WIDTH-1:0] MEM_DIN,
    input  logic [DD_WIDTH-1:0] MEM_DOUT,
    output logic                MEM_EN,
    output logic                MEM_WE
`ifdef BF_DP_TRAP_EN
    ,
    output logic                ERR
`endif
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RD   = 2'd1;
    localparam logic [1:0] ST_EX   = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [2:0] CMD_NOP   = 3'd0;
    localparam logic [2:0] CMD_INC   = 3'd1;
    localparam logic [2:0] CMD_DEC   = 3'd2;
    localparam logic [2:0] CMD_LEFT  = 3'd3;
    localparam logic [2:0] CMD_RIGHT = 3'd4;
    localparam logic [2:0] CMD_LOAD  = 3'd5;
    localparam logic [2:0] CMD_STORE = 3'd6;
    localparam logic [2:0] CMD_CLEAR = 3'd7;

`ifdef BF_DP_TRAP_EN
    localparam bit DP_TRAP = 1'b1;
`else
    localparam bit DP_TRAP = 1'b0;
`endif

    logic [1:0]          state_reg;
    logic [2:0]          cmd_reg;
    logic [DD_WIDTH-1:0] wdata_reg;
    logic [DA_WIDTH-1:0] dp_reg, dp_next;
    logic [DD_WIDTH-1:0] rsp_data_reg;
    logic                rsp_zero_reg;
    logic                accept;
    logic                left_blocked, right_blocked;
    logic                is_write;
    logic [DD_WIDTH-1:0] new_val;

    assign accept        = (state_reg == ST_IDLE) && CMD_VALID;
    assign left_blocked  = DP_TRAP && (dp_reg == '0);
    assign right_blocked = DP_TRAP && (dp_reg == '1);
    assign is_write      = (cmd_reg == CMD_INC) || (cmd_reg == CMD_DEC) ||
                           (cmd_reg == CMD_STORE) || (cmd_reg == CMD_CLEAR);

    // Pointer moves take effect on the acceptance edge so the following read sees the new cell.
    always_comb begin
        dp_next = dp_reg;
        if (accept) begin
            if (CMD == CMD_LEFT && !left_blocked)
                dp_next = dp_reg - DA_WIDTH'(1);
            else if (CMD == CMD_RIGHT && !right_blocked)
                dp_next = dp_reg + DA_WIDTH'(1);
        end
    end

    always_comb begin
        new_val = MEM_DOUT;
        case (cmd_reg)
            CMD_INC:   new_val = MEM_DOUT + DD_WIDTH'(1);
            CMD_DEC:   new_val = MEM_DOUT - DD_WIDTH'(1);
            CMD_STORE: new_val = wdata_reg;
            CMD_CLEAR: new_val = '0;
            default:   new_val = MEM_DOUT;
        endcase
    end

    // RAM strobes depend only on registered state, never on the incoming request.
    always_comb begin
        MEM_EN  = 1'b0;
        MEM_WE  = 1'b0;
        MEM_A   = '0;
        MEM_DIN = '0;
        if (state_reg == ST_RD) begin
            MEM_EN = 1'b1;
            MEM_A  = dp_reg;
        end else if (state_reg == ST_EX && is_write) begin
            MEM_EN  = 1'b1;
            MEM_WE  = 1'b1;
            MEM_A   = dp_reg;
            MEM_DIN = new_val;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_reg    <= ST_IDLE;
            cmd_reg      <= CMD_NOP;
            wdata_reg    <= '0;
            dp_reg       <= '0;
            rsp_data_reg <= '0;
            rsp_zero_reg <= 1'b1;
        end else begin
            dp_reg <= dp_next;
            case (state_reg)
                ST_IDLE: begin
                    if (CMD_VALID) begin
                        cmd_reg   <= CMD;
                        wdata_reg <= WDATA;
                        state_reg <= (CMD == CMD_NOP) ? ST_DONE : ST_RD;
                    end
                end
                ST_RD:   state_reg <= ST_EX;
                ST_EX: begin
                    rsp_data_reg <= new_val;
                    rsp_zero_reg <= (new_val == '0);
                    state_reg    <= ST_DONE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

`ifdef BF_DP_TRAP_EN
    logic err_reg;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            err_reg <= 1'b0;
        else if (accept && ((CMD == CMD_LEFT && left_blocked) || (CMD == CMD_RIGHT && right_blocked)))
            err_reg <= 1'b1;
    end

    assign ERR = err_reg;
`endif

    assign CMD_READY = (state_reg == ST_IDLE);
    assign RSP_VALID = (state_reg == ST_DONE);
    assign RSP_DATA  = rsp_data_reg;
    assign RSP_ZERO  = rsp_zero_reg;
    assign DP        = dp_reg;

endmodule

// File: tb/tb_bf_data_unit.sv
// Self-checking bench for bf_data_unit: directed plan steps followed by random commands against a cell-level model.
// Honours BF_DP_TRAP_EN the same way as the design.
module tb_bf_data_unit;

    localparam int AW    = 11;
    localparam int DW    = 8;
    localparam int DEPTH = 1 << AW;

    logic          CLK = 1'b0;
    logic          RST_N;
    logic          CMD_VALID;
    logic          CMD_READY;
    logic [2:0]    CMD;
    logic [DW-1:0] WDATA;
    logic          RSP_VALID;
    logic [DW-1:0] RSP_DATA;
    logic          RSP_ZERO;
    logic [AW-1:0] DP;
    logic [AW-1:0] MEM_A;
    logic [DW-1:0] MEM_DIN;
    logic [DW-1:0] MEM_DOUT;
    logic          MEM_EN;
    logic          MEM_WE;
`ifdef BF_DP_TRAP_EN
    logic          ERR;
    logic          ref_err;
`endif

    always #5 CLK = ~CLK;

    bf_data_unit #(.DA_WIDTH(AW), .DD_WIDTH(DW)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD(CMD), .WDATA(WDATA),
        .RSP_VALID(RSP_VALID), .RSP_DATA(RSP_DATA), .RSP_ZERO(RSP_ZERO), .DP(DP),
        .MEM_A(MEM_A), .MEM_DIN(MEM_DIN), .MEM_DOUT(MEM_DOUT),
        .MEM_EN(MEM_EN), .MEM_WE(MEM_WE)
`ifdef BF_DP_TRAP_EN
        , .ERR(ERR)
`endif
    );

    function automatic logic [DW-1:0] fill_val(input int i);
        return (i == 0) ? '0 : DW'((i * 37 + 11) % 256);
    endfunction

    // Synchronous single-port RAM attached to the unit
    logic [DW-1:0] ram [DEPTH];
    logic [DW-1:0] ram_dout;
    assign MEM_DOUT = ram_dout;
    initial begin
        for (int i = 0; i < DEPTH; i++) ram[i] = fill_val(i);
        ram_dout = '0;
        forever begin
            @(posedge CLK);
            if (MEM_EN) begin
                if (MEM_WE) ram[MEM_A] <= MEM_DIN;
                ram_dout <= ram[MEM_A];
            end
        end
    end

    // Bus monitor, sampled mid-cycle
    int            en_total = 0;
    int            we_total = 0;
    logic [AW-1:0] rd_addr;
    logic [AW-1:0] we_addr;
    logic [DW-1:0] we_data;
    always @(negedge CLK) begin
        if (MEM_EN) begin
            en_total++;
            if (MEM_WE) begin
                we_total++;
                we_addr = MEM_A;
                we_data = MEM_DIN;
            end else begin
                rd_addr = MEM_A;
            end
        end
    end

    int            checks = 0;
    int            failures = 0;
    logic [DW-1:0] ref_mem [DEPTH];
    int            ref_dp;
    logic [DW-1:0] ref_rsp;
    time           t_acc;
    int            last_wait;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs();
        chk("rst_ready", CMD_READY, 1);
        chk("rst_rsp_valid", RSP_VALID, 0);
        chk("rst_rsp_data", RSP_DATA, 0);
        chk("rst_rsp_zero", RSP_ZERO, 1);
        chk("rst_dp", DP, 0);
        chk("rst_mem_en", MEM_EN, 0);
        chk("rst_mem_we", MEM_WE, 0);
        chk("rst_mem_a", MEM_A, 0);
        chk("rst_mem_din", MEM_DIN, 0);
`ifdef BF_DP_TRAP_EN
        chk("rst_err", ERR, 0);
`endif
    endtask

    // Issue one command (called 1ns after a rising edge or at a falling edge) and check it against the model.
    task automatic do_cmd(input logic [2:0] c, input logic [DW-1:0] wd, input bit keep);
        int waited = 0;
        int lat = 0;
        int en0, we0, exp_en, exp_lat;
        bit wr;
        logic [DW-1:0] v;
        CMD = c;
        WDATA = wd;
        CMD_VALID = 1'b1;
        while (!CMD_READY && waited < 20) begin
            @(posedge CLK); #1;
            waited++;
        end
        chk("accept_wait", (waited < 20), 1);
        last_wait = waited;
        en0 = en_total;
        we0 = we_total;
        @(posedge CLK);
        t_acc = $time;
        #1;
        if (!keep) CMD_VALID = 1'b0;

        wr = (c == 3'd1) || (c == 3'd2) || (c == 3'd6) || (c == 3'd7);
        if (c == 3'd3) begin
`ifdef BF_DP_TRAP_EN
            if (ref_dp == 0) ref_err = 1'b1; else
`endif
            ref_dp = (ref_dp + DEPTH - 1) % DEPTH;
        end else if (c == 3'd4) begin
`ifdef BF_DP_TRAP_EN
            if (ref_dp == DEPTH - 1) ref_err = 1'b1; else
`endif
            ref_dp = (ref_dp + 1) % DEPTH;
        end
        if (c != 3'd0) begin
            v = ref_mem[ref_dp];
            case (c)
                3'd1: v = DW'((int'(v) + 1) % 256);
                3'd2: v = DW'((int'(v) + 255) % 256);
                3'd6: v = wd;
                3'd7: v = '0;
                default: ;
            endcase
            if (wr) ref_mem[ref_dp] = v;
            ref_rsp = v;
        end
        exp_lat = (c == 3'd0) ? 0 : 2;
        exp_en  = (c == 3'd0) ? 0 : (wr ? 2 : 1);

        while (!RSP_VALID && lat < 10) begin
            @(posedge CLK); #1;
            lat++;
        end
        chk("rsp_latency", lat, exp_lat);
        chk("rsp_data", RSP_DATA, ref_rsp);
        chk("rsp_zero", RSP_ZERO, (ref_rsp == 0));
        chk("dp", DP, ref_dp);
        @(posedge CLK); #1;
        chk("rsp_pulse", RSP_VALID, 0);
        chk("mem_en_cycles", en_total - en0, exp_en);
        chk("mem_we_cycles", we_total - we0, wr ? 1 : 0);
        if (c != 3'd0) chk("rd_addr", rd_addr, ref_dp);
        if (wr) begin
            chk("we_addr", we_addr, ref_dp);
            chk("we_data", we_data, ref_rsp);
        end
        chk("ram_cell", ram[ref_dp], ref_mem[ref_dp]);
`ifdef BF_DP_TRAP_EN
        chk("err", ERR, ref_err);
`endif
        $display("TXN cmd=%0d wdata=%02h dp=%03h rsp=%02h zero=%0d lat=%0d", c, wd, DP, RSP_DATA, RSP_ZERO, lat);
    endtask

    initial begin
        time t1;
        logic [AW-1:0] hold_addr;
        logic [DW-1:0] hold_val;

        for (int i = 0; i < DEPTH; i++) ref_mem[i] = fill_val(i);
        ref_dp = 0;
        ref_rsp = '0;
`ifdef BF_DP_TRAP_EN
        ref_err = 1'b0;
`endif
        RST_N = 1'b0;
        CMD_VALID = 1'b0;
        CMD = 3'd0;
        WDATA = '0;
        #22;
        chk_reset_outputs();
        @(negedge CLK);
        RST_N = 1'b1;
        #1;
        chk_reset_outputs();
        @(negedge CLK);

        // 1: LOAD of a zero cell
        do_cmd(3'd5, 8'h00, 0);
        chk("p1_rsp", RSP_DATA, 8'h00);
        // 2: INC x3, DEC, LOAD
        do_cmd(3'd1, 8'h00, 0);
        do_cmd(3'd1, 8'h00, 0);
        do_cmd(3'd1, 8'h00, 0);
        chk("p2_after_inc3", RSP_DATA, 8'h03);
        do_cmd(3'd2, 8'h00, 0);
        do_cmd(3'd5, 8'h00, 0);
        chk("p2_load", RSP_DATA, 8'h02);
        // 3: STORE, RIGHT, STORE, LEFT
        do_cmd(3'd6, 8'hA5, 0);
        do_cmd(3'd4, 8'h00, 0);
        do_cmd(3'd6, 8'h3C, 0);
        do_cmd(3'd3, 8'h00, 0);
        chk("p3_rsp", RSP_DATA, 8'hA5);
        chk("p3_dp", DP, 0);
        chk("p3_ram1", ram[1], 8'h3C);
        // 4: CLEAR, DEC wraps, INC wraps back
        do_cmd(3'd7, 8'h00, 0);
        do_cmd(3'd2, 8'h00, 0);
        chk("p4_dec_rsp", RSP_DATA, 8'hFF);
        chk("p4_dec_zero", RSP_ZERO, 0);
        do_cmd(3'd1, 8'h00, 0);
        chk("p4_inc_rsp", RSP_DATA, 8'h00);
        chk("p4_inc_zero", RSP_ZERO, 1);
        // 5: LEFT at pointer 0
        do_cmd(3'd3, 8'h00, 0);
`ifdef BF_DP_TRAP_EN
        chk("p5_dp_trap", DP, 0);
        chk("p5_err", ERR, 1);
`else
        chk("p5_dp_wrap", DP, 11'h7FF);
        chk("p5_rsp", RSP_DATA, fill_val(DEPTH - 1));
`endif
        do_cmd(3'd4, 8'h00, 0);
        // NOP keeps response, then back-to-back throughput with a held request
        do_cmd(3'd0, 8'h00, 1);
        t1 = t_acc;
        do_cmd(3'd0, 8'h00, 0);
        chk("nop_throughput", 32'((t_acc - t1) / 10), 2);
        do_cmd(3'd1, 8'h00, 1);
        t1 = t_acc;
        do_cmd(3'd1, 8'h00, 0);
        chk("cmd_throughput", 32'((t_acc - t1) / 10), 4);

        // 6: reset during the write cycle of an INC
        do_cmd(3'd4, 8'h00, 0);
        CMD = 3'd1;
        CMD_VALID = 1'b1;
        @(posedge CLK); #1;
        CMD_VALID = 1'b0;
        @(posedge CLK); #1;
        hold_addr = DP;
        hold_val = ram[hold_addr];
        chk("p6_in_ex_we", MEM_WE, 1);
        #2;
        RST_N = 1'b0;
        #1;
        chk_reset_outputs();
        CMD = 3'd5;
        CMD_VALID = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        chk("p6_no_write", ram[hold_addr], hold_val);
        chk("p6_no_write_model", ram[hold_addr], ref_mem[hold_addr]);
        ref_dp = 0;
        ref_rsp = '0;
`ifdef BF_DP_TRAP_EN
        ref_err = 1'b0;
`endif
        @(negedge CLK);
        RST_N = 1'b1;
        do_cmd(3'd5, 8'h00, 0);
        chk("p6_first_edge_accept", last_wait, 0);

        // Random commands against the model
        for (int n = 0; n < 150; n++)
            do_cmd(3'($urandom_range(0, 7)), DW'($urandom), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

endmodule
